prbs_stream_checker: RTL and testbench
======================================

Name: prbs_stream_checker

Overview:
- Self-synchronising parallel PRBS checker; consumes the N-bit-per-cycle estimated-bit word from the FFE/CDR slicer path.
- Predicts each bit from the stream's own history using a programmable tap equation.
- Accumulates 64-bit error and total-bit counts under a 2-bit mode control.
- The counts feed the JTAG registers prbs_err_bits_upper/lower and prbs_total_bits_upper/lower.

Parameters:
- N, 16, bits per input word (equals Nti).
- NPRBS, 32, tap-equation width and history depth in bits.
- CNT_W, 64, counter width.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  data_in valid this cycle.
- data_in  in  N  received bits; bit 0 is earliest in time, bit N-1 latest.
- prbs_eqn  in  NPRBS  tap mask; bit j set means the delay-(j+1) bit is XORed into the prediction. Quasi-static.
- mode  in  2  0=CLEAR, 1=ALIGN, 2=RUN, 3=FREEZE.
- err_bits  out  CNT_W  accumulated error count.
- total_bits  out  CNT_W  accumulated checked-bit count.
- err_flags  out  N  per-bit mismatch of the most recently checked word.
- hist_ok  out  1  history holds at least NPRBS valid bits.

Behaviour:
- Reset: with rst=1 at a clock edge, all outputs, the history register, hist_cnt and pipeline valids go to 0 at that edge. rst overrides mode and en.
- Stage 0 (input register):
  - Registers data_in, en and mode.
  - mode travels down the pipeline with its data so that counting stays aligned with mode changes.
- Stage 1 (check):
  - Form the sequence s = {word, hist}, where hist holds the previous NPRBS bits.
  - pred[i] = XOR over j of (prbs_eqn[j] & s[i-(j+1)]).
  - err[i] = word[i] ^ pred[i].
  - When the stage-0 valid is set: hist shifts by N with the new word; hist_cnt (saturating at ceil(NPRBS/N)) increments; err_flags registers err. Otherwise hist, hist_cnt and err_flags hold.
- Stage 2 (accumulate): on a valid word whose carried mode is RUN and with hist_ok=1:
  - total_bits += N.
  - err_bits += popcount(err).
- Latency: a word at the data_in edge is reflected in err_flags after 2 edges and in the counters after 3 edges.
- Mode behaviour, as carried with the data:
  - CLEAR: counters and err_flags go to 0; hist and hist_cnt clear; data is ignored.
  - ALIGN: hist updates; counters hold.
  - RUN: count as above. Words arriving while hist_ok=0 update hist but are not counted.
  - FREEZE: counters hold exactly; hist still updates, so a return to RUN needs no realign.
- hist_ok = (hist_cnt == ceil(NPRBS/N)). With the defaults, that is 2 valid words after CLEAR or rst.
- Saturation: each counter saturates at 2^CNT_W-1 and never wraps. err_bits saturates independently of total_bits.
- en=0 cycles are bubbles: no history, counter or flag change.
- A mode change mid-pipeline applies per word. Words already in flight retain the mode they were sampled with.
- prbs_eqn = 0: pred = 0, so err equals the data. This is legal, with no special handling.
- Moving from CLEAR directly to RUN is legal; the first ceil(NPRBS/N) words are uncounted.

Test Plan:
- Reset: rst=1 for 2 cycles with random data and mode=2 → all outputs 0; with rst=0, hist_ok rises 2 valid words later.
- Clean PRBS7:
  - Stimulus: eqn bits 5 and 6 set; mode CLEAR→RUN; 1000 valid words of the x^7+x^6+1 sequence.
  - Required: err_bits=0; total_bits=(1000-2)*16=15968, since the first 2 words fill history; err_flags=0.
- Single injected flip:
  - Stimulus: clean PRBS7 in RUN, then bit 3 of one word flipped.
  - Required: err_bits=3, one for the bad bit and one for each of its tap uses at delays 6 and 7. err_flags shows bit 3 on that word plus the follow-on positions.
- Freeze and bubbles:
  - Stimulus: RUN for 100 words, then FREEZE for 50 words with errors injected, then RUN for 100 words; also en=0 on every 3rd cycle.
  - Required: counters unchanged through FREEZE; total_bits=200*16; bubbles add nothing.
- Mode pipeline alignment: switch mode 2→3 on the same edge a valid word enters → that word is not counted; the word before it is counted.
- Saturation: preload near-max by forcing internal counters to 2^64-5, then 1 word with 16 errors → err_bits=2^64-1 with no wrap; total_bits likewise saturates.

Source files
------------

// File: rtl/prbs_stream_checker.sv
// -----------------------------------------------------------------------------
// prbs_stream_checker
//
// Self-synchronising parallel PRBS checker. Each N-bit word from the slicer
// path is checked against a prediction built from the stream's own recent
// history. The prediction uses a programmable tap equation. Error and
// checked-bit counts are accumulated in saturating counters, which feed the
// prbs_err_bits_* / prbs_total_bits_* JTAG registers.
//
// Pipeline:
//   stage 0 : registers data_in / en / mode
//   stage 1 : prediction, per-bit error flags, history update
//   stage 2 : saturating accumulation
// The mode travels with each word, so a mode change applies per word.
//
// Ports:
//   clk        core clock, rising edge
//   rst        synchronous active-high reset (overrides en and mode)
//   en         data_in valid this cycle
//   data_in    N received bits, bit 0 earliest in time
//   prbs_eqn   tap mask, bit j = delay-(j+1) bit feeds the prediction
//   mode       0=CLEAR 1=ALIGN 2=RUN 3=FREEZE
//   err_bits   accumulated error count (saturating)
//   total_bits accumulated checked-bit count (saturating)
//   err_flags  per-bit mismatch of the most recently checked word
//   hist_ok    history holds at least NPRBS valid bits
// -----------------------------------------------------------------------------
module prbs_stream_checker #(
   parameter int N     = 16,
   parameter int NPRBS = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N-1:0]     data_in,
   input  logic [NPRBS-1:0] prbs_eqn,
   input  logic [1:0]       mode,
   output logic [CNT_W-1:0] err_bits,
   output logic [CNT_W-1:0] total_bits,
   output logic [N-1:0]     err_flags,
   output logic             hist_ok
);

   // Number of valid words needed before the history is completely filled.
   localparam int HIST_WORDS = (NPRBS + N - 1) / N;
   localparam int HC_W       = $clog2(HIST_WORDS + 1);
   localparam int POP_W      = $clog2(N + 1);
   localparam logic [HC_W-1:0] HC_FULL = HC_W'(HIST_WORDS);

   typedef enum logic [1:0] {
      MODE_CLEAR  = 2'd0,
      MODE_ALIGN  = 2'd1,
      MODE_RUN    = 2'd2,
      MODE_FREEZE = 2'd3
   } mode_t;

   // ---------------- stage 0 : input register ----------------
   logic           valid0_reg;
   logic [N-1:0]   data0_reg;
   mode_t          mode0_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid0_reg <= 1'b0;
         data0_reg  <= '0;
         mode0_reg  <= MODE_CLEAR;
      end else begin
         valid0_reg <= en;
         data0_reg  <= data_in;
         mode0_reg  <= mode_t'(mode);
      end
   end

   // ---------------- stage 1 : check ----------------
   // hist_reg[NPRBS-1] is the bit immediately before data0_reg[0].
   logic [NPRBS-1:0]   hist_reg;
   logic [HC_W-1:0]    hist_cnt_reg;
   logic [N-1:0]       err_flags_reg;
   logic               valid1_reg;
   mode_t              mode1_reg;
   logic               count_ok1_reg;
   logic [POP_W-1:0]   pop1_reg;

   logic [N+NPRBS-1:0] seq;
   logic [N-1:0]       pred;
   logic [N-1:0]       err;
   logic [POP_W-1:0]   err_pop;
   logic [NPRBS-1:0]   hist_next;

   // seq[k] is the k-th bit in time order; the current word occupies the top.
   assign seq       = {data0_reg, hist_reg};
   assign hist_next = seq[N+NPRBS-1 -: NPRBS];

   // Each predicted bit XORs the tapped bits at delays 1..NPRBS before it.
   // Taps can reach back into the same word, which is why seq spans both.
   for (genvar gi = 0; gi < N; gi++) begin : g_pred
      logic [NPRBS-1:0] tap_terms;
      for (genvar gj = 0; gj < NPRBS; gj++) begin : g_tap
         assign tap_terms[gj] = prbs_eqn[gj] & seq[NPRBS + gi - 1 - gj];
      end
      assign pred[gi] = ^tap_terms;
   end

   assign err     = data0_reg ^ pred;
   assign err_pop = POP_W'($countones(err));
   assign hist_ok = (hist_cnt_reg == HC_FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_reg      <= '0;
         hist_cnt_reg  <= '0;
         err_flags_reg <= '0;
         valid1_reg    <= 1'b0;
         mode1_reg     <= MODE_CLEAR;
         count_ok1_reg <= 1'b0;
         pop1_reg      <= '0;
      end else begin
         valid1_reg    <= valid0_reg;
         mode1_reg     <= mode0_reg;
         // Eligibility depends on the history as it was when this word was
         // predicted, not on the history after it has been absorbed.
         count_ok1_reg <= hist_ok;
         pop1_reg      <= err_pop;
         if (valid0_reg) begin
            if (mode0_reg == MODE_CLEAR) begin
               hist_reg      <= '0;
               hist_cnt_reg  <= '0;
               err_flags_reg <= '0;
            end else begin
               // ALIGN, RUN and FREEZE all keep the history tracking the
               // line, so a return to RUN needs no realignment.
               hist_reg      <= hist_next;
               err_flags_reg <= err;
               if (hist_cnt_reg != HC_FULL) begin
                  hist_cnt_reg <= hist_cnt_reg + HC_W'(1);
               end
            end
         end
      end
   end

   // ---------------- stage 2 : accumulate ----------------
   logic [CNT_W-1:0] err_bits_reg;
   logic [CNT_W-1:0] total_bits_reg;
   logic [CNT_W:0]   err_sum;
   logic [CNT_W:0]   total_sum;
   logic [CNT_W-1:0] err_bits_next;
   logic [CNT_W-1:0] total_bits_next;

   // One extra bit of headroom exposes the carry used for saturation.
   assign err_sum   = {1'b0, err_bits_reg}   + (CNT_W+1)'(pop1_reg);
   assign total_sum = {1'b0, total_bits_reg} + (CNT_W+1)'(N);

   assign err_bits_next   = err_sum[CNT_W]   ? '1 : err_sum[CNT_W-1:0];
   assign total_bits_next = total_sum[CNT_W] ? '1 : total_sum[CNT_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         err_bits_reg   <= '0;
         total_bits_reg <= '0;
      end else if (valid1_reg) begin
         case (mode1_reg)
            MODE_CLEAR: begin
               err_bits_reg   <= '0;
               total_bits_reg <= '0;
            end
            MODE_RUN: begin
               if (count_ok1_reg) begin
                  err_bits_reg   <= err_bits_next;
                  total_bits_reg <= total_bits_next;
               end
            end
            default: begin
               // ALIGN and FREEZE hold the counters.
            end
         endcase
      end
   end

   assign err_bits   = err_bits_reg;
   assign total_bits = total_bits_reg;
   assign err_flags  = err_flags_reg;

endmodule

// File: tb/tb_prbs_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_stream_checker
//
// Drives PRBS7 traffic into two checker instances (64-bit counters and an
// 8-bit-counter copy whose counters saturate quickly). A bit-serial reference
// predictor computes the expected flags and counts for every valid word at
// drive time and queues them; a negedge monitor pops and compares them when
// the pipeline should have produced them.
// -----------------------------------------------------------------------------
module tb_prbs_stream_checker;

   localparam int N     = 16;
   localparam int NPRBS = 32;
   localparam int CNT_W = 64;
   localparam int NW    = 8;
   localparam int NMAX  = 255;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en  = 1'b0;
   logic [N-1:0]     data_in = '0;
   logic [NPRBS-1:0] prbs_eqn = 32'h0000_0060;
   logic [1:0]       mode = 2'd2;

   logic [CNT_W-1:0] err_bits;
   logic [CNT_W-1:0] total_bits;
   logic [N-1:0]     err_flags;
   logic             hist_ok;

   logic [NW-1:0]    err_bits_n;
   logic [NW-1:0]    total_bits_n;
   logic [N-1:0]     err_flags_n;
   logic             hist_ok_n;

   always #5 clk = ~clk;

   prbs_stream_checker #(.N(N), .NPRBS(NPRBS), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .data_in    (data_in),
      .prbs_eqn   (prbs_eqn),
      .mode       (mode),
      .err_bits   (err_bits),
      .total_bits (total_bits),
      .err_flags  (err_flags),
      .hist_ok    (hist_ok)
   );

   prbs_stream_checker #(.N(N), .NPRBS(NPRBS), .CNT_W(NW)) dut_sat (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .data_in    (data_in),
      .prbs_eqn   (prbs_eqn),
      .mode       (mode),
      .err_bits   (err_bits_n),
      .total_bits (total_bits_n),
      .err_flags  (err_flags_n),
      .hist_ok    (hist_ok_n)
   );

   int total_cnt = 0;
   int bad_cnt   = 0;
   int cyc       = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      int           due;
      logic [N-1:0] flags;
      logic         ok;
   } flag_exp_t;

   typedef struct {
      int              due;
      longint unsigned err;
      longint unsigned tot;
      int              errn;
      int              totn;
   } cnt_exp_t;

   flag_exp_t fq[$];
   cnt_exp_t  cq[$];

   // Reference model state: m_hist[0] is the most recent bit (delay 1).
   logic [NPRBS-1:0] m_hist = '0;
   int               m_cnt  = 0;
   longint unsigned  m_err  = 0;
   longint unsigned  m_tot  = 0;
   int               m_errn = 0;
   int               m_totn = 0;

   // PRBS7 generator, x^7+x^6+1: g[0] is the newest bit.
   logic [6:0] gen = 7'h7f;

   task automatic next_prbs(output logic [N-1:0] w);
      logic b;
      for (int i = 0; i < N; i++) begin
         b    = gen[5] ^ gen[6];
         gen  = {gen[5:0], b};
         w[i] = b;
      end
   endtask

   task automatic model_word(input logic [1:0] m, input logic [N-1:0] d);
      logic [N-1:0] ef;
      logic         p;
      logic         ok_before;
      int           pc;
      flag_exp_t    fe;
      cnt_exp_t     ce;
      ef = '0;
      if (m == 2'd0) begin
         m_hist = '0;
         m_cnt  = 0;
         m_err  = 0;
         m_tot  = 0;
         m_errn = 0;
         m_totn = 0;
      end else begin
         for (int i = 0; i < N; i++) begin
            p      = ^(m_hist & prbs_eqn);
            ef[i]  = d[i] ^ p;
            m_hist = {m_hist[NPRBS-2:0], d[i]};
         end
         ok_before = (m_cnt == 2);
         if (m_cnt < 2) m_cnt++;
         if (m == 2'd2 && ok_before) begin
            pc     = $countones(ef);
            m_err  = m_err + longint'(pc);
            m_tot  = m_tot + longint'(N);
            m_errn = (m_errn + pc > NMAX) ? NMAX : m_errn + pc;
            m_totn = (m_totn + N  > NMAX) ? NMAX : m_totn + N;
         end
      end
      fe.due   = cyc + 2;
      fe.flags = ef;
      fe.ok    = (m_cnt == 2);
      fq.push_back(fe);
      ce.due  = cyc + 3;
      ce.err  = m_err;
      ce.tot  = m_tot;
      ce.errn = m_errn;
      ce.totn = m_totn;
      cq.push_back(ce);
   endtask

   // Called at a negedge: presents one cycle of stimulus, then waits a cycle.
   task automatic drive(input logic v, input logic [1:0] m, input logic [N-1:0] d);
      en      = v;
      mode    = m;
      data_in = d;
      if (v) model_word(m, d);
      @(negedge clk);
   endtask

   task automatic bubbles(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, mode, N'($urandom));
   endtask

   flag_exp_t mf;
   cnt_exp_t  mc;

   always @(negedge clk) begin
      while (fq.size() > 0 && fq[0].due <= cyc) begin
         mf = fq.pop_front();
         chk("err_flags",   64'(err_flags),   64'(mf.flags));
         chk("hist_ok",     64'(hist_ok),     64'(mf.ok));
         chk("err_flags_n", 64'(err_flags_n), 64'(mf.flags));
      end
      while (cq.size() > 0 && cq[0].due <= cyc) begin
         mc = cq.pop_front();
         chk("err_bits",     err_bits,             mc.err);
         chk("total_bits",   total_bits,           mc.tot);
         chk("err_bits_n",   64'(err_bits_n),      64'(mc.errn));
         chk("total_bits_n", 64'(total_bits_n),    64'(mc.totn));
         $display("txn cyc=%0d err_bits=%0d total_bits=%0d err_n=%0d tot_n=%0d",
                  cyc, err_bits, total_bits, err_bits_n, total_bits_n);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   logic [N-1:0] w;
   int           wi;
   int           t;
   logic [1:0]   m;

   initial begin
      // ---- reset with busy inputs ----
      rst     = 1'b1;
      en      = 1'b1;
      mode    = 2'd2;
      data_in = N'($urandom);
      @(negedge clk);
      data_in = N'($urandom);
      @(negedge clk);
      chk("rst_err_bits",   err_bits,           64'd0);
      chk("rst_total_bits", total_bits,         64'd0);
      chk("rst_err_flags",  64'(err_flags),     64'd0);
      chk("rst_hist_ok",    64'(hist_ok),       64'd0);
      chk("rst_err_n",      64'(err_bits_n),    64'd0);
      chk("rst_tot_n",      64'(total_bits_n),  64'd0);
      rst = 1'b0;
      en  = 1'b0;
      @(negedge clk);

      // ---- straight into RUN after reset: hist_ok after 2 words ----
      for (int i = 0; i < 4; i++) begin
         next_prbs(w);
         drive(1'b1, 2'd2, w);
      end
      bubbles(4);

      // ---- clean PRBS7: CLEAR then 1000 RUN words ----
      drive(1'b1, 2'd0, N'($urandom));
      for (int i = 0; i < 1000; i++) begin
         next_prbs(w);
         drive(1'b1, 2'd2, w);
      end
      bubbles(4);
      chk("clean_err_bits",   err_bits,       64'd0);
      chk("clean_total_bits", total_bits,     64'd15968);
      chk("clean_err_flags",  64'(err_flags), 64'd0);

      // ---- single flipped bit 3 in one word ----
      for (int i = 0; i < 20; i++) begin
         next_prbs(w);
         if (i == 10) w[3] = ~w[3];
         drive(1'b1, 2'd2, w);
      end
      bubbles(4);
      chk("flip_err_bits",   err_bits,   64'd3);
      chk("flip_total_bits", total_bits, 64'd16288);

      // ---- freeze with errors, bubbles every 3rd cycle ----
      drive(1'b1, 2'd0, N'($urandom));
      for (int i = 0; i < 2; i++) begin
         next_prbs(w);
         drive(1'b1, 2'd1, w);
      end
      wi = 0;
      t  = 0;
      while (wi < 250) begin
         if (t % 3 == 2) begin
            drive(1'b0, mode, N'($urandom));
         end else begin
            m = (wi < 100) ? 2'd2 : (wi < 150) ? 2'd3 : 2'd2;
            next_prbs(w);
            if (wi >= 100 && wi < 140) w[wi % N] = ~w[wi % N];
            drive(1'b1, m, w);
            wi++;
         end
         t++;
      end
      bubbles(4);
      chk("freeze_total_bits", total_bits, 64'd3200);
      chk("freeze_err_bits",   err_bits,   64'd0);

      // ---- mode switch on back-to-back words ----
      next_prbs(w);
      drive(1'b1, 2'd2, w);
      next_prbs(w);
      drive(1'b1, 2'd3, w);
      bubbles(4);
      chk("align_total_a", total_bits, 64'd3216);
      next_prbs(w);
      drive(1'b1, 2'd2, w);
      bubbles(4);
      chk("align_total_b", total_bits, 64'd3232);

      // ---- saturation: eqn=0 so each 16'hffff word is 16 errors ----
      prbs_eqn = '0;
      bubbles(2);
      drive(1'b1, 2'd0, '0);
      drive(1'b1, 2'd1, '0);
      drive(1'b1, 2'd1, '0);
      for (int i = 0; i < 17; i++) drive(1'b1, 2'd2, 16'hffff);
      bubbles(4);
      chk("sat_err_n",   64'(err_bits_n),   64'd255);
      chk("sat_tot_n",   64'(total_bits_n), 64'd255);
      chk("sat_err_w",   err_bits,          64'd272);
      chk("sat_tot_w",   total_bits,        64'd272);
      chk("sat_flags",   64'(err_flags),    64'hffff);

      bubbles(3);
      chk("queues_drained", 64'(fq.size() + cq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
